// File: rtl/m2_block_writer_if.sv
// Bus bundle for the IDCT block writer: start request, dual-port RAM read side and SRAM write side.
interface m2_block_writer_if;
    logic        Start;
    logic [1:0]  Plane;
    logic [5:0]  Block_col;
    logic [4:0]  Block_row;
    logic [5:0]  DP_address;
    logic [31:0] DP_read_data;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        Busy;
    logic        Done;

    modport master (
        output Start, Plane, Block_col, Block_row, DP_read_data,
        input  DP_address, SRAM_address, SRAM_write_data, SRAM_we_n, Busy, Done
    );

    modport slave (
        input  Start, Plane, Block_col, Block_row, DP_read_data,
        output DP_address, SRAM_address, SRAM_write_data, SRAM_we_n, Busy, Done
    );
endinterface

// File: rtl/m2_block_writer.sv
// Writes one 8x8 block of IDCT results from the dual-port RAM into the Y/U/V region of SRAM,
// clipping each value to 8 bits and packing pixel pairs into 16-bit words.
module m2_block_writer #(
    parameter logic [17:0] Y_BASE    = 18'd0,
    parameter logic [17:0] U_BASE    = 18'd38400,
    parameter logic [17:0] V_BASE    = 18'd57600,
    parameter logic [17:0] Y_STRIDE  = 18'd160,
    parameter logic [17:0] UV_STRIDE = 18'd80
) (
    input  logic               Clock,
    input  logic               Resetn,
    m2_block_writer_if.slave   bus
);

    localparam int unsigned AW  = 18;
    localparam int unsigned DPW = 6;
    localparam int unsigned WCW = 5;

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD_IN, S_RD_EVEN, S_RD_ODD, S_LEAD_OUT, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [DPW-1:0]   dp_addr_q, dp_addr_d;
    logic [AW-1:0]    sram_addr_q, sram_addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             we_n_q, we_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [AW-1:0]    stride_q, stride_d;
    logic [AW-1:0]    row_base_q, row_base_d;
    logic [7:0]       hold_q, hold_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;

    logic [AW-1:0]    stride_sel, plane_base, row_off, base_sel;
    logic [DPW-1:0]   dp_next;

    function automatic logic [7:0] clip8(input logic signed [31:0] v);
        if (v < 32'sd0)        return 8'd0;
        else if (v > 32'sd255) return 8'd255;
        else                   return v[7:0];
    endfunction

    // Block origin in SRAM for the requested plane/row/column (wraps at 18 bits)
    always_comb begin
        stride_sel = (bus.Plane == 2'd0) ? Y_STRIDE : UV_STRIDE;
        case (bus.Plane)
            2'd0:    plane_base = Y_BASE;
            2'd1:    plane_base = U_BASE;
            default: plane_base = V_BASE;
        endcase
        row_off  = AW'({13'd0, bus.Block_row} * stride_sel);
        base_sel = AW'(plane_base + AW'(row_off << 3) + AW'({10'd0, bus.Block_col, 2'b00}));
        dp_next  = (dp_addr_q == DPW'(63)) ? dp_addr_q : DPW'(dp_addr_q + DPW'(1));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        dp_addr_d   = dp_addr_q;
        sram_addr_d = sram_addr_q;
        wdata_d     = wdata_q;
        we_n_d      = 1'b1;
        busy_d      = busy_q;
        done_d      = 1'b0;
        stride_d    = stride_q;
        row_base_d  = row_base_q;
        hold_d      = hold_q;
        wcnt_d      = wcnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.Start && (bus.Plane != 2'd3)) begin
                    state_d    = S_LEAD_IN;
                    busy_d     = 1'b1;
                    dp_addr_d  = '0;
                    stride_d   = stride_sel;
                    row_base_d = base_sel;
                    wcnt_d     = '0;
                end
            end
            S_LEAD_IN: begin
                dp_addr_d = dp_next;
                state_d   = S_RD_EVEN;
            end
            S_RD_EVEN: begin
                hold_d    = clip8(bus.DP_read_data);
                dp_addr_d = dp_next;
                state_d   = S_RD_ODD;
            end
            S_RD_ODD: begin
                wdata_d     = {hold_q, clip8(bus.DP_read_data)};
                sram_addr_d = AW'(row_base_q + AW'(wcnt_q[1:0]));
                we_n_d      = 1'b0;
                wcnt_d      = WCW'(wcnt_q + WCW'(1));
                dp_addr_d   = dp_next;
                // Fourth word of a row: advance to the next image row
                if (wcnt_q[1:0] == 2'd3) row_base_d = AW'(row_base_q + stride_q);
                state_d     = (wcnt_q == WCW'(31)) ? S_LEAD_OUT : S_RD_EVEN;
            end
            S_LEAD_OUT: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            dp_addr_q   <= '0;
            sram_addr_q <= '0;
            wdata_q     <= '0;
            we_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stride_q    <= '0;
            row_base_q  <= '0;
            hold_q      <= '0;
            wcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            dp_addr_q   <= dp_addr_d;
            sram_addr_q <= sram_addr_d;
            wdata_q     <= wdata_d;
            we_n_q      <= we_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stride_q    <= stride_d;
            row_base_q  <= row_base_d;
            hold_q      <= hold_d;
            wcnt_q      <= wcnt_d;
        end
    end

    assign bus.DP_address      = dp_addr_q;
    assign bus.SRAM_address    = sram_addr_q;
    assign bus.SRAM_write_data = wdata_q;
    assign bus.SRAM_we_n       = we_n_q;
    assign bus.Busy            = busy_q;
    assign bus.Done            = done_q;

endmodule

// File: tb/tb_m2_block_writer.sv
// Self-checking bench for m2_block_writer: randomized RAM contents checked against a
// behavioural model of block placement, clipping and write timing.
module tb_m2_block_writer;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   mem [64];
    logic [31:0] ram_q;
    int   wr_addr [$];
    int   wr_data [$];

    m2_block_writer_if bus();

    m2_block_writer dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port RAM model with one-cycle read latency
    always @(posedge clk) ram_q <= 32'(mem[bus.DP_address]);
    assign bus.DP_read_data = ram_q;

    function automatic int clip8(input int v);
        if (v < 0)   return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int plane_base(input int plane);
        if (plane == 0) return 0;
        if (plane == 1) return 38400;
        return 57600;
    endfunction

    task automatic fill_random(input int lo, input int hi);
        for (int i = 0; i < 64; i++) mem[i] = lo + int'($urandom_range(0, hi - lo));
    endtask

    // Runs one block from a Start pulse and checks every cycle through the Done pulse
    task automatic run_block(input int plane, input int col, input int row,
                             input bit disturb, input string name);
        int stride, base, nwr, ea, ed;
        bit exp_busy, exp_done, exp_we;
        int exp_dp;
        wr_addr.delete();
        wr_data.delete();
        stride = (plane == 0) ? 160 : 80;
        base   = plane_base(plane) + row * 8 * stride + col * 4;
        nwr    = 0;
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Plane = 2'(plane);
        bus.Block_col = 6'(col);
        bus.Block_row = 5'(row);
        for (int c = 1; c <= 68; c++) begin
            @(negedge clk);
            if (c == 1) bus.Start = 1'b0;
            if (disturb && (c == 10 || c == 40)) begin
                bus.Start = 1'b1;
                bus.Plane = 2'($urandom_range(0, 3));
                bus.Block_col = 6'($urandom_range(0, 39));
                bus.Block_row = 5'($urandom_range(0, 29));
            end
            if (disturb && (c == 11 || c == 41)) bus.Start = 1'b0;
            exp_busy = (c <= 66);
            exp_done = (c == 67);
            exp_we   = (c >= 4 && c <= 66 && (c % 2) == 0);
            exp_dp   = (c <= 64) ? c - 1 : 63;
            n_checks += 4;
            if (bus.Busy !== exp_busy) begin
                n_errors++;
                $display("FAIL %s busy cycle %0d got %b exp %b", name, c, bus.Busy, exp_busy);
            end
            if (bus.Done !== exp_done) begin
                n_errors++;
                $display("FAIL %s done cycle %0d got %b exp %b", name, c, bus.Done, exp_done);
            end
            if (bus.SRAM_we_n !== !exp_we) begin
                n_errors++;
                $display("FAIL %s we_n cycle %0d got %b exp %b", name, c, bus.SRAM_we_n, !exp_we);
            end
            if (bus.DP_address !== 6'(exp_dp)) begin
                n_errors++;
                $display("FAIL %s dp_addr cycle %0d got %0d exp %0d", name, c, bus.DP_address, exp_dp);
            end
            if (bus.SRAM_we_n === 1'b0) begin
                wr_addr.push_back(int'(bus.SRAM_address));
                wr_data.push_back(int'(bus.SRAM_write_data));
                if (nwr < 32) begin
                    ea = (base + (nwr / 4) * stride + (nwr % 4)) & 32'h3FFFF;
                    ed = clip8(mem[2*nwr]) * 256 + clip8(mem[2*nwr + 1]);
                    n_checks += 2;
                    if (int'(bus.SRAM_address) != ea) begin
                        n_errors++;
                        $display("FAIL %s addr word %0d got %0d exp %0d", name, nwr, bus.SRAM_address, ea);
                    end
                    if (int'(bus.SRAM_write_data) != ed) begin
                        n_errors++;
                        $display("FAIL %s data word %0d got %h exp %h", name, nwr, bus.SRAM_write_data, 16'(ed));
                    end
                end
                nwr++;
            end
        end
        n_checks++;
        if (nwr != 32) begin
            n_errors++;
            $display("FAIL %s write_count got %0d exp 32", name, nwr);
        end
    endtask

    // Checks the idle/reset output values at the current moment
    task automatic check_reset_values(input string name);
        n_checks++;
        if (bus.DP_address !== 6'd0 || bus.SRAM_address !== 18'd0 || bus.SRAM_write_data !== 16'd0 ||
            bus.SRAM_we_n !== 1'b1 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            n_errors++;
            $display("FAIL %s reset_values got dp=%0d addr=%0d data=%h we_n=%b busy=%b done=%b exp 0 0 0 1 0 0",
                     name, bus.DP_address, bus.SRAM_address, bus.SRAM_write_data,
                     bus.SRAM_we_n, bus.Busy, bus.Done);
        end
    endtask

    // Watches a span of cycles in which nothing may be written or started
    task automatic expect_quiet(input int cycles, input string name);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (c == 0) bus.Start = 1'b0;
            n_checks++;
            if (bus.SRAM_we_n !== 1'b1 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
                n_errors++;
                $display("FAIL %s quiet cycle %0d got we_n=%b busy=%b done=%b exp 1 0 0",
                         name, c, bus.SRAM_we_n, bus.Busy, bus.Done);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.Start = 1'b0;
        bus.Plane = 2'd0;
        bus.Block_col = 6'd0;
        bus.Block_row = 5'd0;
        for (int i = 0; i < 64; i++) mem[i] = 0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("after_reset");
    endtask

    task automatic test_y_origin();
        for (int i = 0; i < 64; i++) mem[i] = i;
        run_block(0, 0, 0, 1'b0, "y_origin");
        n_checks += 3;
        if (wr_data.size() != 32 || wr_data[0] != 32'h0001 || wr_data[31] != 32'h3E3F) begin
            n_errors++;
            $display("FAIL y_origin words got size=%0d w0=%h w31=%h exp 32 0001 3e3f",
                     wr_data.size(), wr_data.size() > 0 ? wr_data[0] : -1,
                     wr_data.size() > 31 ? wr_data[31] : -1);
        end
        if (wr_addr.size() != 32 || wr_addr[4] != 160 || wr_addr[31] != 1123) begin
            n_errors++;
            $display("FAIL y_origin rows got size=%0d exp 32 a4=160 a31=1123", wr_addr.size());
        end
        if (wr_addr.size() == 32 && wr_addr[0] != 0) begin
            n_errors++;
            $display("FAIL y_origin first_addr got %0d exp 0", wr_addr[0]);
        end
    endtask

    task automatic test_plane_corners();
        fill_random(0, 255);
        run_block(0, 39, 29, 1'b0, "y_corner");
        n_checks++;
        if (wr_addr.size() != 32 || wr_addr[0] != 37276 || wr_addr[31] != 38399) begin
            n_errors++;
            $display("FAIL y_corner bounds got size=%0d exp 32 first 37276 last 38399", wr_addr.size());
        end
        fill_random(-50, 300);
        run_block(1, 19, 29, 1'b0, "u_corner");
        n_checks++;
        if (wr_addr.size() != 32 || wr_addr[0] != 57036 || wr_addr[31] != 57599) begin
            n_errors++;
            $display("FAIL u_corner bounds got size=%0d exp 32 first 57036 last 57599", wr_addr.size());
        end
        fill_random(-50, 300);
        run_block(2, 0, 0, 1'b0, "v_origin");
        n_checks++;
        if (wr_addr.size() != 32 || wr_addr[0] != 57600 || wr_addr[4] != 57680) begin
            n_errors++;
            $display("FAIL v_origin bounds got size=%0d exp 32 first 57600 row1 57680", wr_addr.size());
        end
    endtask

    task automatic test_clip();
        int expw [3];
        fill_random(-2000, 2000);
        mem[0] = -300; mem[1] = 1000; mem[2] = 0; mem[3] = 255; mem[4] = 256; mem[5] = 128;
        expw[0] = 32'h00FF; expw[1] = 32'h00FF; expw[2] = 32'hFF80;
        run_block(1, 5, 7, 1'b0, "clip");
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (wr_data.size() <= i || wr_data[i] != expw[i]) begin
                n_errors++;
                $display("FAIL clip word %0d got %h exp %h", i,
                         wr_data.size() > i ? wr_data[i] : -1, 16'(expw[i]));
            end
        end
    endtask

    task automatic test_random_blocks();
        int p;
        for (int t = 0; t < 5; t++) begin
            p = int'($urandom_range(0, 2));
            fill_random(-100000, 100000);
            if (t % 2 == 0) fill_random(-40, 300);
            run_block(p, int'($urandom_range(0, (p == 0) ? 39 : 19)), int'($urandom_range(0, 29)),
                      1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        fill_random(-20, 280);
        run_block(0, 3, 4, 1'b0, "b2b_first");
        fill_random(-20, 280);
        run_block(2, 19, 0, 1'b0, "b2b_second");
    endtask

    task automatic test_ignore();
        fill_random(-20, 280);
        run_block(0, 12, 13, 1'b1, "busy_restart");
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Plane = 2'd3;
        bus.Block_col = 6'd1;
        bus.Block_row = 5'd1;
        expect_quiet(75, "illegal_plane");
    endtask

    task automatic test_reset_mid();
        fill_random(0, 255);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Plane = 2'd0;
        bus.Block_col = 6'd2;
        bus.Block_row = 5'd3;
        for (int c = 1; c < 30; c++) begin
            @(negedge clk);
            bus.Start = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet(80, "after_abort");
        fill_random(-20, 280);
        run_block(0, 2, 3, 1'b0, "after_abort_block");
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        test_reset();
        test_y_origin();
        test_plane_corners();
        test_clip();
        test_random_blocks();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout got no completion exp finish");
        $fatal(1, "timeout");
    end

endmodule
